adc_sample_avg: RTL and testbench

ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

---
 rtl/adc_sample_avg.sv | 110 +++++++++++
 tb/tb_adc_sample_avg.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/adc_sample_avg.sv
// Sliding-window averager for an upstream sweep ADC: edge-detects drdy_in,
// keeps an N-deep ring buffer with running sum, and reports the average with hysteresis.
module adc_sample_avg #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned THRESH_HI  = 128,
  parameter int unsigned THRESH_LO  = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             drdy_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             above_thresh,
  output logic             filled
);

  localparam int unsigned N  = 1 << DEPTH_LOG2;
  localparam int unsigned SW = WIDTH + DEPTH_LOG2;
  localparam logic [WIDTH-1:0]      HI_T     = WIDTH'(THRESH_HI);
  localparam logic [WIDTH-1:0]      LO_T     = WIDTH'(THRESH_LO);
  localparam logic [DEPTH_LOG2-1:0] LAST_CNT = DEPTH_LOG2'(N - 1);

  typedef enum logic {FILL, RUN} state_e;

  state_e                state_q, state_d;
  logic                  drdy_q;
  logic [WIDTH-1:0]      samp_q [N];
  logic [WIDTH-1:0]      samp_d [N];
  logic [SW-1:0]         sum_q, sum_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] fill_cnt_q, fill_cnt_d;
  logic [WIDTH-1:0]      avg_q, avg_d;
  logic                  avg_valid_q, avg_valid_d;
  logic                  above_q, above_d;

  logic                  accept;
  logic [SW-1:0]         new_sum;
  logic [WIDTH-1:0]      new_avg;

  always_comb begin
    accept  = enable & drdy_in & ~drdy_q & ~flush;
    // The oldest entry is already part of sum_q, so the subtraction cannot underflow.
    new_sum = sum_q + SW'(data_in) - SW'(samp_q[wr_ptr_q]);
    new_avg = WIDTH'(new_sum >> DEPTH_LOG2);

    state_d     = state_q;
    samp_d      = samp_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    above_d     = above_q;

    // Flush is a window-clear command and acts whether or not sampling is enabled.
    if (flush) begin
      state_d    = FILL;
      for (int unsigned i = 0; i < N; i++) samp_d[i] = '0;
      sum_d      = '0;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
    end else if (accept) begin
      samp_d[wr_ptr_q] = data_in;
      sum_d            = new_sum;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      if (state_q == FILL) fill_cnt_d = fill_cnt_q + 1'b1;
      if (state_q == RUN || fill_cnt_q == LAST_CNT) begin
        state_d     = RUN;
        avg_d       = new_avg;
        avg_valid_d = 1'b1;
        if (new_avg >= HI_T)      above_d = 1'b1;
        else if (new_avg <= LO_T) above_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      drdy_q      <= 1'b1;
      for (int unsigned i = 0; i < N; i++) samp_q[i] <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      above_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      drdy_q      <= drdy_in;
      samp_q      <= samp_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      above_q     <= above_d;
    end
  end

  assign avg_out      = avg_q;
  assign avg_valid    = avg_valid_q;
  assign above_thresh = above_q;
  assign filled       = (state_q == RUN);

endmodule

// File: tb/tb_adc_sample_avg.sv
// Directed table-driven bench for adc_sample_avg with default parameters.
module tb_adc_sample_avg;

  logic       clk = 1'b0;
  logic       reset, enable, flush, drdy_in;
  logic [7:0] data_in;
  logic [7:0] avg_out;
  logic       avg_valid, above_thresh, filled;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] data;
    logic       en;
    logic       fl;
    logic       ev;
    logic [7:0] eavg;
    logic       eabove;
    logic       efilled;
  } row_t;

  row_t tbl[$];
  row_t rst_tbl[$];

  adc_sample_avg #(.WIDTH(8), .DEPTH_LOG2(2), .THRESH_HI(128), .THRESH_LO(96)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .drdy_in(drdy_in),
    .data_in(data_in), .avg_out(avg_out), .avg_valid(avg_valid),
    .above_thresh(above_thresh), .filled(filled)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(int d, bit en, bit fl, bit ev, int eavg, bit eab, bit ef);
    row_t r;
    r.data = 8'(d); r.en = en; r.fl = fl; r.ev = ev;
    r.eavg = 8'(eavg); r.eabove = eab; r.efilled = ef;
    return r;
  endfunction

  task automatic chk(string name, int got, int exp);
    total++;
    if (got != exp) $display("FAIL %s got %0d exp %0d", name, got, exp);
    else passed++;
  endtask

  // One drdy low->high transition, then check outputs right after the accept edge.
  task automatic apply(string tag, int idx, row_t r);
    @(posedge clk); #1 drdy_in = 1'b0;
    @(posedge clk); #1 drdy_in = 1'b1; data_in = r.data; enable = r.en; flush = r.fl;
    @(posedge clk); #1 flush = 1'b0; enable = 1'b1;
    chk($sformatf("%s%0d_valid", tag, idx), int'(avg_valid), int'(r.ev));
    chk($sformatf("%s%0d_avg", tag, idx), int'(avg_out), int'(r.eavg));
    chk($sformatf("%s%0d_above", tag, idx), int'(above_thresh), int'(r.eabove));
    chk($sformatf("%s%0d_filled", tag, idx), int'(filled), int'(r.efilled));
    @(posedge clk); #1;
    chk($sformatf("%s%0d_pulse_end", tag, idx), int'(avg_valid), 0);
  endtask

  initial begin
    int pulses;

    // fill, slide with wrap
    tbl.push_back(mk(10, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(20, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(30, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(40, 1, 0, 1, 25, 0, 1));
    tbl.push_back(mk(50, 1, 0, 1, 35, 0, 1));
    tbl.push_back(mk(60, 1, 0, 1, 45, 0, 1));
    // flush with a discarded edge, then hysteresis run
    tbl.push_back(mk(0, 1, 1, 0, 45, 0, 0));
    tbl.push_back(mk(200, 1, 0, 0, 45, 0, 0));
    tbl.push_back(mk(200, 1, 0, 0, 45, 0, 0));
    tbl.push_back(mk(200, 1, 0, 0, 45, 0, 0));
    tbl.push_back(mk(200, 1, 0, 1, 200, 1, 1));
    tbl.push_back(mk(100, 1, 0, 1, 175, 1, 1));
    tbl.push_back(mk(100, 1, 0, 1, 150, 1, 1));
    tbl.push_back(mk(100, 1, 0, 1, 125, 1, 1));
    tbl.push_back(mk(100, 1, 0, 1, 100, 1, 1));
    tbl.push_back(mk(90, 1, 0, 1, 97, 1, 1));
    tbl.push_back(mk(90, 1, 0, 1, 95, 0, 1));
    // flush in RUN coinciding with an edge, then refill with 8s
    tbl.push_back(mk(123, 1, 1, 0, 95, 0, 0));
    tbl.push_back(mk(8, 1, 0, 0, 95, 0, 0));
    tbl.push_back(mk(8, 1, 0, 0, 95, 0, 0));
    tbl.push_back(mk(8, 1, 0, 0, 95, 0, 0));
    tbl.push_back(mk(8, 1, 0, 1, 8, 0, 1));

    // after mid-RUN reset; the enable-low edge must not count toward the fill
    rst_tbl.push_back(mk(4, 1, 0, 0, 0, 0, 0));
    rst_tbl.push_back(mk(8, 1, 0, 0, 0, 0, 0));
    rst_tbl.push_back(mk(12, 1, 0, 0, 0, 0, 0));
    rst_tbl.push_back(mk(200, 0, 0, 0, 0, 0, 0));
    rst_tbl.push_back(mk(16, 1, 0, 1, 10, 0, 1));

    reset = 1'b1; enable = 1'b1; flush = 1'b0; drdy_in = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_avg", int'(avg_out), 0);
    chk("reset_valid", int'(avg_valid), 0);
    chk("reset_above", int'(above_thresh), 0);
    chk("reset_filled", int'(filled), 0);
    reset = 1'b0;

    foreach (tbl[i]) apply("row", i, tbl[i]);

    // drdy held high for 10 cycles: window {8,8,8,77} -> 25
    @(posedge clk); #1 drdy_in = 1'b0;
    @(posedge clk); #1 drdy_in = 1'b1; data_in = 8'd77;
    pulses = 0;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      if (avg_valid) pulses++;
    end
    chk("level_pulses", pulses, 1);
    chk("level_avg", int'(avg_out), 25);
    chk("level_filled", int'(filled), 1);

    // reset in RUN with drdy_in still high
    reset = 1'b1; data_in = 8'd99;
    @(posedge clk); #1;
    chk("midrst_avg", int'(avg_out), 0);
    chk("midrst_valid", int'(avg_valid), 0);
    chk("midrst_above", int'(above_thresh), 0);
    chk("midrst_filled", int'(filled), 0);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (avg_valid) pulses++;
    end
    chk("midrst_hold_pulses", pulses, 0);

    foreach (rst_tbl[i]) apply("rst", i, rst_tbl[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
